dct16_reorder_out: RTL and testbench
====================================

Name: dct16_reorder_out

Overview:
Output-end collector for the 16-point DCT sample stream. It receives the unflow-controlled serial stream (in_valid/in_sample) produced by the last butterfly stage. It assembles 16-sample frames into a two-bank ping-pong buffer, undoing the butterfly bit-reversed ordering. Frames are re-emitted in natural coefficient order on a valid/ready interface to the downstream consumer, such as a quantiser or the system bus.

Parameters:
DATA_WIDTH, 16, signed sample width
BIT_REVERSE, 1, 1: write address = bitrev4(input count); 0: write address = input count (natural pass-through)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream sample strobe, no backpressure
in_sample  input  DATA_WIDTH signed  upstream sample
out_valid  output  1  out_sample holds a buffered coefficient
out_ready  input  1  downstream accepts when high with out_valid
out_sample  output  DATA_WIDTH signed  coefficient, natural order
out_index  output  4  coefficient index 0..15 of current out_sample
out_last  output  1  high with out_valid when out_index==15
overflow  output  1  sticky; set when any frame is discarded

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_sample=0, out_index=0, out_last=0, overflow=0. Both bank-full flags are cleared; wr_cnt=0, rd_cnt=0, wr_bank=0, rd_bank=0, writer mode=WRITE. Storage contents are not reset. Reset mid-frame abandons all partial and full frames.
- Storage: 2 banks x 16 x DATA_WIDTH registers, plus full[1:0].
- Writer, per frame:
  - A frame is 16 consecutive accepted in_valid samples, counted by wr_cnt 0..15. Gaps between in_valid pulses are allowed.
  - At wr_cnt==0 with in_valid, the mode is chosen from the registered full[wr_bank]. If 0: WRITE. If 1: DISCARD and overflow<=1. There is no same-cycle bypass of a reader clearing that flag.
  - WRITE: bank[wr_bank][addr(wr_cnt)] <= in_sample. On wr_cnt==15: full[wr_bank]<=1, wr_bank toggles.
  - DISCARD: the sample is counted but not written. wr_bank is unchanged at wr_cnt==15.
  - wr_cnt wraps 15->0 in both modes.
  - A bank that is free at frame start cannot be filled by the reader, so mid-frame collisions are impossible.
- Reader:
  - out_valid = full[rd_bank].
  - out_sample = bank[rd_bank][rd_cnt] when out_valid, else 0.
  - out_index = rd_cnt.
  - All outputs are functions of registered state only. There is no combinational path from in_* or out_ready.
  - Transfer = out_valid & out_ready. On transfer rd_cnt++. At rd_cnt==15: full[rd_bank]<=0, rd_bank toggles, rd_cnt->0.
  - While out_valid & !out_ready, out_sample, out_index and out_last hold stable.
- Simultaneous events: the writer setting full[x] and the reader clearing full[y] at the same edge are independent updates, because x!=y by construction.
- Latency: if the 16th sample is accepted at edge T, out_valid=1 with out_index=0 in the following cycle. Throughput is 1 sample/cycle sustained with out_ready=1.
- Ordering: with BIT_REVERSE=1, output j = input sample number bitrev4(j).
- Arithmetic: none; samples pass bit-exact, sign preserved.
- overflow clears only on reset.

Decomposition:
- Shared package dct16_pkg holds:
  - DCT_N=16 and DCT_LOG2N=4
  - default DATA_WIDTH
  - the bitrev4 function
  - writer mode type {WRITE, DISCARD}
- One natural sub-module: dct16_pingpong_bank. It holds the two-bank register storage plus full flags, with a write port (bank, addr, data, commit) and a read port (bank, addr, release).
- Counters, writer mode and overflow live in the top.

Test Plan:
- Reset: drive 7 samples, then rst_n=0 asynchronously between edges -> outputs 0 immediately. After release, a full 16-sample frame is required before out_valid.
- Single frame: in_sample=0..15 consecutive, out_ready=1 -> out_valid rises the cycle after the 16th input. out_sample sequence = 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15. out_index 0..15, out_last only on the 16th. overflow=0.
- Back-to-back: 4 frames continuous, out_ready=1 -> 64 outputs with no gaps after the initial 16-cycle fill. overflow=0.
- Backpressure/overflow: out_ready=0, push frames A (100..115), B (200..215), C (300..315) -> C discarded, overflow=1 at C's first sample. Then out_ready=1 -> exactly 32 outputs, A then B in bitrev order; C never appears.
- Stall stability: out_ready toggling 1,0,1,0 -> out_sample and out_index unchanged on every out_valid & !out_ready cycle. Still 16 transfers per frame.
- Extremes/natural mode: BIT_REVERSE=0, samples alternating -32768/32767 with in_valid gaps of 0-3 cycles -> outputs in input order, bit-exact.

Source files
------------

// File: rtl/dct16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dct16_pkg
// Brief    : Shared constants, writer mode type and bit-reversal helper for
//            the 16-point DCT output reorder path.
// Revision : 1.0 - initial release
// ============================================================================
package dct16_pkg;

   localparam int DCT_N          = 16;
   localparam int DCT_LOG2N      = 4;
   localparam int DCT_DATA_WIDTH = 16;

   typedef enum logic [0:0] {
      WRITE   = 1'b0,
      DISCARD = 1'b1
   } wr_mode_t;

   function automatic logic [DCT_LOG2N-1:0] bitrev4(input logic [DCT_LOG2N-1:0] v);
      logic [DCT_LOG2N-1:0] r;
      for (int i = 0; i < DCT_LOG2N; i++) begin
         r[i] = v[DCT_LOG2N-1-i];
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dct16_pingpong_bank.sv
`default_nettype none
// ============================================================================
// Module   : dct16_pingpong_bank
// Brief    : Two 16-entry sample banks with per-bank full flags; one write
//            port (commit sets full) and one read port (release clears full).
// Revision : 1.0 - initial release
// ============================================================================
module dct16_pingpong_bank
   import dct16_pkg::*;
#(
   parameter int DATA_WIDTH = DCT_DATA_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wr_en,
   input  logic                          wr_bank,
   input  logic [DCT_LOG2N-1:0]          wr_addr,
   input  logic signed [DATA_WIDTH-1:0]  wr_data,
   input  logic                          wr_commit,
   input  logic                          rd_bank,
   input  logic [DCT_LOG2N-1:0]          rd_addr,
   input  logic                          rd_release,
   output logic signed [DATA_WIDTH-1:0]  rd_data,
   output logic [1:0]                    full
);

   logic signed [DATA_WIDTH-1:0] r_mem [0:1][0:DCT_N-1];
   logic [1:0]                   r_full;

   // Storage is deliberately left unreset; full flags alone qualify it.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_bank][wr_addr] <= wr_data;
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_full
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_full[gi] <= 1'b0;
            end else if (wr_commit && (wr_bank == 1'(gi))) begin
               r_full[gi] <= 1'b1;
            end else if (rd_release && (rd_bank == 1'(gi))) begin
               r_full[gi] <= 1'b0;
            end
         end
      end
   endgenerate

   assign rd_data = r_mem[rd_bank][rd_addr];
   assign full    = r_full;

endmodule
`default_nettype wire

// File: rtl/dct16_reorder_out.sv
`default_nettype none
// ============================================================================
// Module   : dct16_reorder_out
// Brief    : Collects 16-sample butterfly frames into a ping-pong buffer and
//            re-emits them in natural coefficient order over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module dct16_reorder_out
   import dct16_pkg::*;
#(
   parameter int DATA_WIDTH  = DCT_DATA_WIDTH,
   parameter bit BIT_REVERSE = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   input  logic signed [DATA_WIDTH-1:0]  in_sample,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic signed [DATA_WIDTH-1:0]  out_sample,
   output logic [DCT_LOG2N-1:0]          out_index,
   output logic                          out_last,
   output logic                          overflow
);

   localparam logic [DCT_LOG2N-1:0] c_LAST = DCT_LOG2N'(DCT_N - 1);
   localparam logic [DCT_LOG2N-1:0] c_ONE  = DCT_LOG2N'(1);

   logic [DCT_LOG2N-1:0]         r_wr_cnt;
   logic [DCT_LOG2N-1:0]         r_rd_cnt;
   logic                         r_wr_bank;
   logic                         r_rd_bank;
   wr_mode_t                     r_mode;
   logic                         r_overflow;

   wr_mode_t                     w_mode;
   logic                         w_frame_start;
   logic                         w_wr_en;
   logic                         w_commit;
   logic                         w_xfer;
   logic                         w_release;
   logic [DCT_LOG2N-1:0]         w_wr_addr;
   logic signed [DATA_WIDTH-1:0] w_rd_data;
   logic [1:0]                   w_full;

   assign w_frame_start = in_valid && (r_wr_cnt == '0);

   // Mode is decided from the registered flag only; a release at the same edge
   // is not seen, so that frame is dropped rather than racing the reader.
   always_comb begin
      w_mode = r_mode;
      if (w_frame_start) begin
         w_mode = w_full[r_wr_bank] ? DISCARD : WRITE;
      end
   end

   assign w_wr_en  = in_valid && (w_mode == WRITE);
   assign w_commit = w_wr_en && (r_wr_cnt == c_LAST);

   generate
      if (BIT_REVERSE) begin : g_bitrev
         assign w_wr_addr = bitrev4(r_wr_cnt);
      end else begin : g_natural
         assign w_wr_addr = r_wr_cnt;
      end
   endgenerate

   assign out_valid = w_full[r_rd_bank];
   assign w_xfer    = out_valid && out_ready;
   assign w_release = w_xfer && (r_rd_cnt == c_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_cnt   <= '0;
         r_rd_cnt   <= '0;
         r_wr_bank  <= 1'b0;
         r_rd_bank  <= 1'b0;
         r_mode     <= WRITE;
         r_overflow <= 1'b0;
      end else begin
         if (in_valid) begin
            r_wr_cnt <= r_wr_cnt + c_ONE;
            r_mode   <= w_mode;
            if (w_frame_start && (w_mode == DISCARD)) begin
               r_overflow <= 1'b1;
            end
            if (w_commit) begin
               r_wr_bank <= ~r_wr_bank;
            end
         end
         if (w_xfer) begin
            r_rd_cnt <= r_rd_cnt + c_ONE;
            if (w_release) begin
               r_rd_bank <= ~r_rd_bank;
            end
         end
      end
   end

   dct16_pingpong_bank #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (w_wr_en),
      .wr_bank    (r_wr_bank),
      .wr_addr    (w_wr_addr),
      .wr_data    (in_sample),
      .wr_commit  (w_commit),
      .rd_bank    (r_rd_bank),
      .rd_addr    (r_rd_cnt),
      .rd_release (w_release),
      .rd_data    (w_rd_data),
      .full       (w_full)
   );

   assign out_sample = out_valid ? w_rd_data : '0;
   assign out_index  = r_rd_cnt;
   assign out_last   = out_valid && (r_rd_cnt == c_LAST);
   assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_dct16_reorder_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_dct16_reorder_out
// Brief    : Directed self-checking bench for dct16_reorder_out (bit-reversed
//            and natural-order instances driven from shared stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dct16_reorder_out;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic signed [15:0] in_sample;
   logic               out_ready;
   logic               sel;

   logic               br_valid, br_last, br_ovf;
   logic signed [15:0] br_sample;
   logic [3:0]         br_index;
   logic               nt_valid, nt_last, nt_ovf;
   logic signed [15:0] nt_sample;
   logic [3:0]         nt_index;

   logic               mv, ml, mo;
   logic signed [15:0] ms;
   logic [3:0]         mi;

   int                 n_checks = 0;
   int                 n_errors = 0;
   int                 in_q[$];
   int                 exp_q[$];
   int                 gaps;
   int                 br_tbl[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

   always #5 clk = ~clk;

   dct16_reorder_out #(.DATA_WIDTH(16), .BIT_REVERSE(1'b1)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_sample  (in_sample),
      .out_valid  (br_valid),
      .out_ready  (out_ready),
      .out_sample (br_sample),
      .out_index  (br_index),
      .out_last   (br_last),
      .overflow   (br_ovf)
   );

   dct16_reorder_out #(.DATA_WIDTH(16), .BIT_REVERSE(1'b0)) u_dut_nat (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_sample  (in_sample),
      .out_valid  (nt_valid),
      .out_ready  (out_ready),
      .out_sample (nt_sample),
      .out_index  (nt_index),
      .out_last   (nt_last),
      .overflow   (nt_ovf)
   );

   assign mv = sel ? nt_valid  : br_valid;
   assign ms = sel ? nt_sample : br_sample;
   assign mi = sel ? nt_index  : br_index;
   assign ml = sel ? nt_last   : br_last;
   assign mo = sel ? nt_ovf    : br_ovf;

   task automatic chk(input string tag, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic push(input int v);
      in_valid  = 1'b1;
      in_sample = 16'(v);
      tick();
   endtask

   task automatic drive(input int gap_max);
      while (in_q.size() > 0) begin
         int g;
         g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
         in_valid = 1'b0;
         repeat (g) tick();
         push(in_q.pop_front());
      end
      in_valid = 1'b0;
   endtask

   task automatic monitor(input int n, input int budget, input bit toggle, output int gap_cnt);
      int got = 0;
      int cyc = 0;
      bit started = 1'b0;
      bit stalled = 1'b0;
      logic signed [15:0] ps = '0;
      logic [3:0] pi = '0;
      gap_cnt = 0;
      while (got < n && cyc < budget) begin
         out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
         if (mv) begin
            started = 1'b1;
            if (stalled) begin
               chk("hold_sample", ms, ps);
               chk("hold_index", mi, pi);
            end
            chk("out_sample", ms, exp_q[0]);
            chk("out_index", mi, got % 16);
            chk("out_last", ml, (got % 16) == 15);
            if (out_ready) begin
               void'(exp_q.pop_front());
               got++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               ps = ms;
               pi = mi;
            end
         end else if (started) begin
            gap_cnt++;
         end
         tick();
         cyc++;
      end
      chk("stream_count", got, n);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sample = '0;
      out_ready = 1'b0;
      sel       = 1'b0;
      tick();
      chk("reset_valid", mv, 0);
      chk("reset_sample", ms, 0);
      chk("reset_index", mi, 0);
      chk("reset_last", ml, 0);
      chk("reset_overflow", mo, 0);
      #2 rst_n = 1'b1;
      tick();

      // Async reset mid-frame with a full frame pending
      for (int i = 0; i < 16; i++) push(500 + i);
      in_valid = 1'b0;
      chk("pre_reset_valid", mv, 1);
      for (int i = 0; i < 7; i++) push(600 + i);
      in_valid = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", mv, 0);
      chk("async_rst_sample", ms, 0);
      chk("async_rst_index", mi, 0);
      chk("async_rst_last", ml, 0);
      #2 rst_n = 1'b1;
      tick();
      for (int i = 0; i < 15; i++) push(700 + i);
      chk("refill_15_valid", mv, 0);
      push(715);
      in_valid = 1'b0;
      chk("refill_16_valid", mv, 1);
      chk("refill_first", ms, 700);

      // Single frame, bit-reversed order, one-cycle latency
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 15; i++) push(i);
      chk("single_lat_15", mv, 0);
      push(15);
      in_valid = 1'b0;
      chk("single_lat_16", mv, 1);
      for (int j = 0; j < 16; j++) exp_q.push_back(br_tbl[j]);
      monitor(16, 40, 1'b0, gaps);
      chk("single_gaps", gaps, 0);
      chk("single_overflow", mo, 0);

      // Four back-to-back frames
      do_reset();
      for (int i = 0; i < 64; i++) in_q.push_back(2000 + i);
      for (int f = 0; f < 4; f++)
         for (int j = 0; j < 16; j++) exp_q.push_back(2000 + 16 * f + br_tbl[j]);
      fork
         drive(0);
         monitor(64, 200, 1'b0, gaps);
      join
      chk("b2b_gaps", gaps, 0);
      chk("b2b_overflow", mo, 0);

      // Backpressure: third frame must be discarded
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 48; i++) begin
         push((i < 16) ? 100 + i : (i < 32) ? 200 + i - 16 : 300 + i - 32);
         if (i == 31) chk("ovf_before_c", mo, 0);
         if (i == 32) chk("ovf_at_c", mo, 1);
      end
      in_valid = 1'b0;
      for (int j = 0; j < 16; j++) exp_q.push_back(100 + br_tbl[j]);
      for (int j = 0; j < 16; j++) exp_q.push_back(200 + br_tbl[j]);
      monitor(32, 100, 1'b0, gaps);
      repeat (3) tick();
      chk("no_frame_c", mv, 0);
      chk("ovf_sticky", mo, 1);

      // Stall stability with toggling ready
      do_reset();
      for (int i = 0; i < 32; i++) in_q.push_back(1000 + i);
      for (int f = 0; f < 2; f++)
         for (int j = 0; j < 16; j++) exp_q.push_back(1000 + 16 * f + br_tbl[j]);
      fork
         drive(0);
         monitor(32, 200, 1'b1, gaps);
      join
      chk("stall_overflow", mo, 0);

      // Natural order, extreme values, irregular input gaps
      sel = 1'b1;
      do_reset();
      for (int i = 0; i < 16; i++) in_q.push_back((i % 2 == 0) ? -32768 : 32767);
      for (int i = 0; i < 16; i++) in_q.push_back((i % 2 == 0) ? -32768 + i : 32767 - i);
      foreach (in_q[k]) exp_q.push_back(in_q[k]);
      fork
         drive(3);
         monitor(32, 400, 1'b0, gaps);
      join
      chk("natural_overflow", mo, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
